serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Sequencer that performs a WIDTH-bit add or subtract by time-multiplexing a single external combinational 1-bit full adder, LSB first, one bit per clock. It sits between a requester issuing start/operand commands and one shared 1-bit adder cell. It owns the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake, and it produces the full-width result, carry and signed-overflow flags.

## Interface
- WIDTH, 8, operand/result width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = A+B, 1 = A−B; sampled with start
- op_a  in  WIDTH  operand A; sampled with start
- op_b  in  WIDTH  operand B; sampled with start
- bit_a  out  1  to adder input a
- bit_b  out  1  to adder input b
- bit_cin  out  1  to adder carry_in
- bit_sum  in  1  from adder sum
- bit_cout  in  1  from adder carry_out
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  sum/difference; holds until next accepted start
- carry_out  out  1  final carry (for sub: 1 = no borrow)
- overflow  out  1  signed overflow of the operation

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start=1, then:
  - a_sh ← op_a
  - b_sh ← sub ? ~op_b : op_b
  - carry ← sub
  - count ← 0
  - result, carry_out and overflow ← 0
  - go to RUN
- If start=0, stay in IDLE.
- RUN, combinational drive:
  - bit_a = a_sh[0]
  - bit_b = b_sh[0]
  - bit_cin = carry
- RUN, each clock edge:
  - result ← {bit_sum, result[WIDTH-1:1]}
  - carry ← bit_cout
  - a_sh and b_sh shift right by one, zero-filled
  - count ← count+1
- RUN exit:
  - On the edge where count = WIDTH−1: carry_out ← bit_cout; overflow ← bit_cin ^ bit_cout (carry into MSB xor carry out of MSB); go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Start handling:
  - start in RUN or DONE is ignored. It is neither queued nor applied.
  - Operands are not re-sampled mid-operation.
- Adder drive outside RUN: bit_a, bit_b and bit_cin are driven 0.
- Width rules:
  - Result is modulo 2^WIDTH.
  - count is $clog2(WIDTH) bits wide and never exceeds WIDTH−1.
- rst=1 at a clock edge, in any state including mid-RUN:
  - state ← IDLE
  - busy, done, carry_out, overflow and result ← 0
  - Shift registers, carry and count ← 0
  - The in-flight operation is abandoned with no done pulse.
- rst and start both high at the same edge: rst wins and start is dropped.

## Timing
- Reset values: busy=0, done=0, result=0, carry_out=0, overflow=0, bit_a=0, bit_b=0, bit_cin=0.
- Cycle schedule, with edge E0 being the edge that samples start=1 in IDLE:
  - Cycles 1..WIDTH after E0: busy=1.
  - Cycle WIDTH+1: done=1, busy=0; result, carry_out and overflow are valid.
  - Cycle WIDTH+2 (earliest): a new start can be sampled.
- Throughput: one operation per WIDTH+2 cycles.
- The adder path is purely combinational within one cycle. The clock period must exceed the adder settle time plus setup; 10 ns is the bench period.
- result, carry_out and overflow are registered. They stay stable from done until the edge accepting the next start.

## Test plan
- WIDTH=8, add 0x35+0x4A → result=0x7F, carry_out=0, overflow=0, done pulse exactly 9 cycles after start edge, busy high 8 cycles.
- Add 0xFF+0x01 → result=0x00, carry_out=1, overflow=0; add 0x7F+0x01 → result=0x80, carry_out=0, overflow=1.
- sub=1, 0x10−0x20 → result=0xF0, carry_out=0 (borrow), overflow=0; sub=1, 0x80−0x01 → result=0x7F, carry_out=1, overflow=1.
- Pulse start with new operands during RUN cycle 3 and during DONE → first result unaffected, second start ignored, no extra done, FSM returns to IDLE.
- Assert rst in RUN cycle 4 → next cycle busy=0, result=0, bit_* = 0, no done; a fresh start then completes correctly (0x01+0x01 → 0x02).
- Back-to-back: start held high continuously across 3 operations → starts accepted every 10 cycles, each done a single-cycle pulse with correct result.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer driving one shared external 1-bit full adder,
// LSB first, one bit per clock, with start/busy/done handshake and result flags.
//
// state  | meaning
// S_IDLE | waiting for start; adder inputs held at 0
// S_RUN  | one operand bit pair per clock through the external adder
// S_DONE | one-cycle done pulse; result/carry_out/overflow valid
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_cin,
  input  logic             bit_sum,
  input  logic             bit_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               in_run;

  assign in_run  = (state_q == S_RUN);
  assign bit_a   = in_run & a_sh_q[0];
  assign bit_b   = in_run & b_sh_q[0];
  assign bit_cin = in_run & carry_q;

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    carry_d     = carry_q;
    count_d     = count_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_sh_d      = op_a;
          b_sh_d      = sub ? ~op_b : op_b;
          carry_d     = sub;
          count_d     = '0;
          result_d    = '0;
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_RUN;
        end
      end

      S_RUN: begin
        result_d = {bit_sum, result_q[WIDTH-1:1]};
        carry_d  = bit_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        if (count_q == CNT_LAST) begin
          // carry_q is the carry into the MSB here, so xor with carry-out gives signed overflow.
          carry_out_d = bit_cout;
          overflow_d  = carry_q ^ bit_cout;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
          busy_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: behavioural full adder cell plus an
// arithmetic reference model; directed and random operations with immediate assertions.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         bit_a;
  logic         bit_b;
  logic         bit_cin;
  logic         bit_sum;
  logic         bit_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int n_assert = 0;
  int n_fail   = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .bit_a     (bit_a),
    .bit_b     (bit_b),
    .bit_cin   (bit_cin),
    .bit_sum   (bit_sum),
    .bit_cout  (bit_cout),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // The shared 1-bit full adder cell.
  assign bit_sum  = bit_a ^ bit_b ^ bit_cin;
  assign bit_cout = (bit_a & bit_b) | (bit_a & bit_cin) | (bit_b & bit_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned and signed integer arithmetic, no bit-level modelling.
  function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c, output logic v);
    longint ua, ub, sa, sb, sr, ur;
    longint modv;
    modv = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - modv : ua;
    sb = b[W-1] ? ub - modv : ub;
    if (s) begin
      ur = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub;
      c  = (ur >= modv);
      sr = sa + sb;
    end
    r = W'(ur);
    v = (sr > (modv / 2 - 1)) || (sr < -(modv / 2));
  endfunction

  // One full operation from the accepting edge to the first idle cycle.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ec, input logic ev);
    logic [W-1:0] bb;
    bb    = s ? ~b : b;
    sub   = s;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= W + 1; i++) begin
      if (i > 1) tick();
      if (i <= W) begin
        check("run_busy", busy, 1);
        check("run_done", done, 0);
        check("run_bit_a", bit_a, a[i-1]);
        check("run_bit_b", bit_b, bb[i-1]);
        if (i == 1) check("run_cin0", bit_cin, s);
      end else begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("result", result, er);
        check("carry_out", carry_out, ec);
        check("overflow", overflow, ev);
        check("done_bits_idle", {bit_a, bit_b, bit_cin}, 0);
      end
    end
    tick();
    check("after_done", done, 0);
    check("after_busy", busy, 0);
    check("result_hold", result, er);
  endtask

  logic [W-1:0] er;
  logic         ec, ev;
  logic         rs;
  logic [W-1:0] ra, rb;
  logic [W:0]   dir_tab [5][6];
  logic [W-1:0] bb_s [3];
  logic [W-1:0] ba_s [3];
  logic         bs_s [3];

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {carry_out, overflow}, 0);
    check("rst_bits", {bit_a, bit_b, bit_cin}, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Directed vectors: sub, a, b, result, carry_out, overflow.
    dir_tab[0] = '{0, 9'h35, 9'h4A, 9'h7F, 0, 0};
    dir_tab[1] = '{0, 9'hFF, 9'h01, 9'h00, 1, 0};
    dir_tab[2] = '{0, 9'h7F, 9'h01, 9'h80, 0, 1};
    dir_tab[3] = '{1, 9'h10, 9'h20, 9'hF0, 0, 0};
    dir_tab[4] = '{1, 9'h80, 9'h01, 9'h7F, 1, 1};
    for (int k = 0; k < 5; k++) begin
      run_op(dir_tab[k][0][0], dir_tab[k][1][W-1:0], dir_tab[k][2][W-1:0],
             dir_tab[k][3][W-1:0], dir_tab[k][4][0], dir_tab[k][5][0]);
    end

    for (int k = 0; k < 24; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = W'($urandom);
      rb = W'($urandom);
      model(rs, ra, rb, er, ec, ev);
      run_op(rs, ra, rb, er, ec, ev);
    end

    // Start pulses in RUN cycle 3 and in DONE must be ignored.
    sub = 1'b0; op_a = 8'h12; op_b = 8'h34; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; sub = 1'b1; op_a = 8'hFF; op_b = 8'hFF;
    tick();
    start = 1'b0;
    check("ign_busy_c4", busy, 1);
    for (int i = 5; i <= W + 1; i++) tick();
    check("ign_done", done, 1);
    check("ign_result", result, 8'h46);
    check("ign_flags", {carry_out, overflow}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_done_clr", done, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("ign_no_busy", busy, 0);
      check("ign_no_done", done, 0);
    end
    check("ign_result_hold", result, 8'h46);

    // Reset in RUN cycle 4 abandons the operation.
    sub = 1'b0; op_a = 8'h55; op_b = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_result", result, 0);
    check("mrst_flags", {carry_out, overflow}, 0);
    check("mrst_bits", {bit_a, bit_b, bit_cin}, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("mrst_no_done", done, 0);
      check("mrst_no_busy", busy, 0);
    end

    // rst and start together: start is dropped.
    rst = 1'b1; start = 1'b1; op_a = 8'h01; op_b = 8'h01;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    tick();
    check("rst_start_busy2", busy, 0);
    run_op(1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

    // Back-to-back with start held high.
    bs_s[0] = 1'b0; ba_s[0] = 8'h35; bb_s[0] = 8'h4A;
    bs_s[1] = 1'b1; ba_s[1] = 8'h10; bb_s[1] = 8'h20;
    bs_s[2] = 1'b0; ba_s[2] = 8'hFF; bb_s[2] = 8'h01;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sub  = bs_s[k];
      op_a = ba_s[k];
      op_b = bb_s[k];
      model(bs_s[k], ba_s[k], bb_s[k], er, ec, ev);
      for (int c = 1; c <= W + 2; c++) begin
        tick();
        if (c == W + 2) start = (k < 2);
        if (c <= W) begin
          check("b2b_busy", busy, 1);
          check("b2b_done_lo", done, 0);
        end else if (c == W + 1) begin
          check("b2b_done", done, 1);
          check("b2b_result", result, er);
          check("b2b_flags", {carry_out, overflow}, {ec, ev});
        end else begin
          check("b2b_gap_busy", busy, 0);
          check("b2b_gap_done", done, 0);
        end
      end
    end
    start = 1'b0;
    tick();
    check("b2b_end_busy", busy, 0);
    check("b2b_end_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
